// File: rtl/ex_alu_stage.sv
// EX stage of the 16-bit datapath: ALU feeding a single-entry EX/MEM register with valid/ready and flush.
// Build option EX_OVF_DETECT_EN adds a registered signed-overflow flag; without it out_ovf is held at 0.
module ex_alu_stage #(
    parameter int WIDTH  = 16,
    parameter int REG_AW = 3,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_res,
    output logic              out_zero,
    output logic [WIDTH-1:0]  out_b,
    output logic [REG_AW-1:0] out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_ovf
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_PSB = 3'b111;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                load_s;
    logic [WIDTH-1:0]    res_s;
    logic                ovf_s;
    logic [WIDTH-1:0]    res_r;
    logic                zero_r;
    logic [WIDTH-1:0]    b_r;
    logic [REG_AW-1:0]   rd_r;
    logic [CTRL_W-1:0]   ctrl_r;
    logic                ovf_r;

    // SLT is a true signed compare, so it stays correct where A-B would overflow.
    function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [2:0]       op);
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_PSB:  r = b;
            default: r = b;
        endcase
        return r;
    endfunction

`ifdef EX_OVF_DETECT_EN
    function automatic logic ovf_f(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] r,
                                   input logic [2:0]       op);
        logic v;
        v = 1'b0;
        case (op)
            OP_ADD:  v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            default: v = 1'b0;
        endcase
        return v;
    endfunction
`endif

    assign res_s = alu_f(in_a, in_b, in_op);
`ifdef EX_OVF_DETECT_EN
    assign ovf_s = ovf_f(in_a, in_b, res_s, in_op);
`else
    assign ovf_s = 1'b0;
`endif

    assign out_valid = (state_r == ST_FULL);
    assign in_ready  = ~out_valid | out_ready;

    // Next-state and load decision; flush overrides everything except reset.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_valid) begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_FULL;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready && in_valid) begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_FULL;
                    end else if (out_ready) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // EX/MEM payload; result and zero flag are captured from the same ALU output.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_r  <= {WIDTH{1'b0}};
            zero_r <= 1'b0;
            b_r    <= {WIDTH{1'b0}};
            rd_r   <= {REG_AW{1'b0}};
            ctrl_r <= {CTRL_W{1'b0}};
            ovf_r  <= 1'b0;
        end else if (load_s) begin
            res_r  <= res_s;
            zero_r <= (res_s == {WIDTH{1'b0}});
            b_r    <= in_b;
            rd_r   <= in_rd;
            ctrl_r <= in_ctrl;
            ovf_r  <= ovf_s;
        end else begin
            res_r  <= res_r;
            zero_r <= zero_r;
            b_r    <= b_r;
            rd_r   <= rd_r;
            ctrl_r <= ctrl_r;
            ovf_r  <= ovf_r;
        end
    end

    assign out_res  = res_r;
    assign out_zero = zero_r;
    assign out_b    = b_r;
    assign out_rd   = rd_r;
    assign out_ctrl = ctrl_r;
    assign out_ovf  = ovf_r;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed op/arith/handshake scenarios plus a randomized stream
// checked against an integer-arithmetic reference model and an in-order scoreboard.
module tb_ex_alu_stage;
    localparam int W  = 16;
    localparam int RA = 3;
    localparam int CW = 4;

`ifdef EX_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, out_zero, out_ovf;
    logic [W-1:0]  in_a, in_b, out_res, out_b;
    logic [2:0]    in_op;
    logic [RA-1:0] in_rd, out_rd;
    logic [CW-1:0] in_ctrl, out_ctrl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]  res;
        logic          zero;
        logic [W-1:0]  b;
        logic [RA-1:0] rd;
        logic [CW-1:0] ctrl;
        logic          ovf;
    } exp_t;

    exp_t sbq[$];

    ex_alu_stage #(.WIDTH(W), .REG_AW(RA), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_zero(out_zero), .out_b(out_b),
        .out_rd(out_rd), .out_ctrl(out_ctrl), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    function automatic int sval(input logic [W-1:0] v);
        return v[W-1] ? (int'(v) - (1 << W)) : int'(v);
    endfunction

    // Reference: signed integers for arithmetic, overflow = result outside the signed range.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                                   input logic [RA-1:0] rd, input logic [CW-1:0] c);
        exp_t e;
        int sa, sb, full;
        bit ov;
        sa = sval(a);
        sb = sval(b);
        ov = 1'b0;
        full = 0;
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: begin full = sa + sb; e.res = full[W-1:0]; ov = (full > 32767) || (full < -32768); end
            3'd3: begin full = sa - sb; e.res = full[W-1:0]; ov = (full > 32767) || (full < -32768); end
            3'd4: e.res = (sa < sb) ? 16'd1 : 16'd0;
            3'd5: e.res = ~(a | b);
            3'd6: e.res = a ^ b;
            default: e.res = b;
        endcase
        e.zero = (e.res == 16'd0);
        e.b    = b;
        e.rd   = rd;
        e.ctrl = c;
        e.ovf  = OVF_EN && ov;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic [RA-1:0] rd, input logic [CW-1:0] c);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_rd    = rd;
        in_ctrl  = c;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a     = 'x;
        in_b     = 'x;
        in_op    = 'x;
        in_rd    = 'x;
        in_ctrl  = 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if ({out_res, out_zero, out_b, out_rd, out_ctrl, out_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %b %h %h %h %b expected all zero",
                     out_res, out_zero, out_b, out_rd, out_ctrl, out_ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_logic();
        logic [2:0]   ops [4] = '{3'd0, 3'd1, 3'd6, 3'd5};
        logic [W-1:0] exps[4] = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h000F};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 16'hF0F0, 16'h0FF0, ops[i], 3'(i), 4'(i + 3));
            @(negedge clk);
            idle();
            checks++;
            if (out_valid !== 1'b1 || out_res !== exps[i] || out_rd !== 3'(i) || out_ctrl !== 4'(i + 3)) begin
                errors++;
                $display("FAIL logic_op%0d: got v=%b res=%h rd=%h ctrl=%h expected v=1 res=%h rd=%h ctrl=%h",
                         ops[i], out_valid, out_res, out_rd, out_ctrl, exps[i], 3'(i), 4'(i + 3));
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL logic_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_arith();
        logic [W-1:0] av [5] = '{16'h7FFF, 16'h0005, 16'hFFFF, 16'h8000, 16'h1234};
        logic [W-1:0] bv [5] = '{16'h0001, 16'h0005, 16'h0001, 16'h7FFF, 16'hBEEF};
        logic [2:0]   opv[5] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd7};
        logic [W-1:0] rv [5] = '{16'h8000, 16'h0000, 16'h0001, 16'h0001, 16'hBEEF};
        logic         zv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic         ov [5];
        ov = '{OVF_EN, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, av[i], bv[i], opv[i], 3'd7, 4'hA);
            @(negedge clk);
            idle();
            checks++;
            if (out_valid !== 1'b1 || out_res !== rv[i] || out_zero !== zv[i] || out_ovf !== ov[i]
                || out_b !== bv[i]) begin
                errors++;
                $display("FAIL arith_%0d: got v=%b res=%h z=%b ovf=%b b=%h expected v=1 res=%h z=%b ovf=%b b=%h",
                         i, out_valid, out_res, out_zero, out_ovf, out_b, rv[i], zv[i], ov[i], bv[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        exp_t e1, e2;
        e1 = model(16'h1111, 16'h2222, 3'd2, 3'd1, 4'h1);
        e2 = model(16'h4444, 16'h0003, 3'd3, 3'd2, 4'h2);
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 16'h1111, 16'h2222, 3'd2, 3'd1, 4'h1);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 16'h4444, 16'h0003, 3'd3, 3'd2, 4'h2);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_res !== e1.res || out_rd !== e1.rd
                || out_ctrl !== e1.ctrl) begin
                errors++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b res=%h rd=%h expected rdy=0 v=1 res=%h rd=%h",
                         i, in_ready, out_valid, out_res, out_rd, e1.res, e1.rd);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_res !== e2.res || out_rd !== e2.rd || out_ctrl !== e2.ctrl) begin
            errors++;
            $display("FAIL bp_next: got v=%b res=%h rd=%h ctrl=%h expected v=1 res=%h rd=%h ctrl=%h",
                     out_valid, out_res, out_rd, out_ctrl, e2.res, e2.rd, e2.ctrl);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 16'h0F0F, 16'h00FF, 3'd1, 3'd3, 4'h3);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_full: got %b expected 1", out_valid); end
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'hAAAA, 16'h5555, 3'd6, 3'd5, 4'h5);
        @(negedge clk);
        flush = 1'b0;
        idle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b expected 0", out_valid); end
        // Reset during a stall must drop the held entry even with flush asserted.
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 16'h0001, 3'd2, 3'd4, 4'h4);
        @(negedge clk);
        idle();
        rst = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_res !== 16'h0000 || out_rd !== 3'd0) begin
            errors++;
            $display("FAIL rst_stall: got v=%b res=%h rd=%h expected v=0 res=0000 rd=0", out_valid, out_res, out_rd);
        end
    endtask

    task automatic test_stream();
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        exp_t e;
        logic [W-1:0] a, b;
        sbq.delete();
        while ((sent < 8 || got < 8) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (out_valid !== (sbq.size() != 0)) begin
                errors++;
                $display("FAIL stream_valid: got %b expected %b at cycle %0d", out_valid, sbq.size() != 0, cyc);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 8 && $urandom_range(0, 1) == 1) begin
                a = 16'($urandom);
                b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
                drive(1'b1, a, b, 3'($urandom_range(0, 7)), 3'($urandom), 4'($urandom));
            end else begin
                idle();
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got unexpected entry res=%h expected none", out_res);
                end else begin
                    e = sbq.pop_front();
                    if ({out_res, out_zero, out_b, out_rd, out_ctrl, out_ovf}
                        !== {e.res, e.zero, e.b, e.rd, e.ctrl, e.ovf}) begin
                        errors++;
                        $display("FAIL stream_data%0d: got %h/%b/%h/%h/%h/%b expected %h/%b/%h/%h/%h/%b", got,
                                 out_res, out_zero, out_b, out_rd, out_ctrl, out_ovf,
                                 e.res, e.zero, e.b, e.rd, e.ctrl, e.ovf);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sbq.push_back(model(in_a, in_b, in_op, in_rd, in_ctrl));
                sent++;
            end
        end
        idle();
        checks++;
        if (sent < 8 || got < 8) begin
            errors++;
            $display("FAIL stream_timeout: got sent=%0d received=%0d expected 8/8", sent, got);
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_arith();
        test_backpressure();
        test_flush();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
